stream_mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a shared 4-to-1 32-bit stream mux in the 2x2 CGRA fabric.

---
 rtl/cgra_stream_pkg.sv | 30 +++
 rtl/stream_mux4_rr_arbiter_rr_pick4.sv | 19 +
 rtl/stream_mux4_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_stream_mux4_rr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_stream_pkg.sv
// Shared types and helpers for the CGRA stream arbitration blocks.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package cgra_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_REQ = 4;

    // Rotating-priority search: first requester set after last_grant, wrapping mod 4.
    // With no request set the result is 0; callers qualify it with |req.
    function automatic logic [1:0] rr_next(input logic [1:0]       last_grant,
                                           input logic [N_REQ-1:0] req);
        logic [1:0] idx;
        logic       found;
        rr_next = 2'd0;
        found   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last_grant + 2'(i);
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/stream_mux4_rr_arbiter_rr_pick4.sv
// Rotate-priority encoder: picks the next requester after the previous grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_pick4
    import cgra_stream_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic [1:0]       idx,
    output logic             any
);

    // Priority search starts one past the last grant so every port gets a turn.
    always_comb begin
        idx = rr_next(last, req);
        any = |req;
    end

endmodule

// File: rtl/stream_mux4_rr_arbiter.sv
// Round-robin 4:1 stream arbiter holding each grant for a whole packet (or MAX_BEATS beats).
// Latency: 1 cycle from in_valid to the first offered beat; 1 idle cycle between grants.
// Backpressure: out_ready passes combinationally to in_ready of the granted port only.
module stream_mux4_rr_arbiter
    import cgra_stream_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ-1:0]        in_last,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [1:0]              sel,
    output logic                    busy
);

    state_t            state;
    state_t            state_next;
    logic [1:0]        last_grant;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W:0]    cnt_plus1;
    logic [1:0]        pick_idx;
    logic              pick_any;
    logic              mux_valid;
    logic              mux_last;
    logic [DATA_W-1:0] mux_data;
    logic              at_limit;
    logic              beat;
    logic              release_now;

    rr_pick4 u_pick (
        .req  (in_valid),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Select the granted stream; unknown select values fall back to port 0.
    always_comb begin
        mux_valid = in_valid[0];
        mux_last  = in_last[0];
        mux_data  = in_data[0 +: DATA_W];
        case (sel)
            2'd1: begin
                mux_valid = in_valid[1];
                mux_last  = in_last[1];
                mux_data  = in_data[DATA_W +: DATA_W];
            end
            2'd2: begin
                mux_valid = in_valid[2];
                mux_last  = in_last[2];
                mux_data  = in_data[2*DATA_W +: DATA_W];
            end
            2'd3: begin
                mux_valid = in_valid[3];
                mux_last  = in_last[3];
                mux_data  = in_data[3*DATA_W +: DATA_W];
            end
            default: begin
                mux_valid = in_valid[0];
                mux_last  = in_last[0];
                mux_data  = in_data[0 +: DATA_W];
            end
        endcase
    end

    // Downstream handshake, beat-limit detection and release; in_ready depends only on state/sel/out_ready.
    always_comb begin
        busy        = (state == BUSY);
        cnt_plus1   = {1'b0, beat_cnt} + (CNT_W+1)'(1);
        at_limit    = (MAX_BEATS != 0) && (cnt_plus1 == (CNT_W+1)'(MAX_BEATS));
        out_valid   = busy & mux_valid;
        out_data    = mux_data;
        out_last    = busy & (mux_last | at_limit);
        beat        = out_valid & out_ready;
        release_now = beat & (mux_last | at_limit);
        in_ready    = '0;
        if (busy) begin
            in_ready[sel] = out_ready;
        end
    end

    // Next state: grab a requester when idle, drop back to idle on the releasing beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any)    state_next = BUSY;
            BUSY:    if (release_now) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant index, round-robin pointer and per-grant beat counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel        <= 2'd0;
            last_grant <= 2'd3;
            beat_cnt   <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                sel <= pick_idx;
            end
            if (release_now) begin
                last_grant <= sel;
                beat_cnt   <= '0;
            end else if (beat && beat_cnt != '1) begin
                // Saturates rather than wrapping when the limit is disabled.
                beat_cnt <= cnt_plus1[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_stream_mux4_rr_arbiter.sv
// Directed bench for the 4:1 round-robin stream arbiter with a beat scoreboard.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready directly.
module tb_stream_mux4_rr_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;
    localparam int CW = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      in_valid;
    logic [3:0]      in_last;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [1:0]      sel;
    logic            busy;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]  port;
        logic        last;
        logic [31:0] data;
    } exp_t;

    beat_t      src_q[4][$];
    exp_t       exp_q[$];
    logic [3:0] pause;
    logic [3:0] acc;
    int         n_total = 0;
    int         n_pass  = 0;
    int         gorder[5];

    always #5 clock = ~clock;

    stream_mux4_rr_arbiter #(
        .DATA_W    (DW),
        .MAX_BEATS (MB),
        .CNT_W     (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    function automatic logic [31:0] mk(input int tag, input int port, input int b);
        return {8'(tag), 8'(port), 16'(b)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                in_valid[i]         = !pause[i];
                in_last[i]          = src_q[i][0].last;
                in_data[i*32 +: 32] = src_q[i][0].data;
            end else begin
                in_valid[i]         = 1'b0;
                in_last[i]          = 1'b0;
                in_data[i*32 +: 32] = '0;
            end
        end
    endtask

    // One clock: score any beat at the negedge, then advance sources just after the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        acc = 4'b0000;
        if (!reset) begin
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_last", 32'(out_last), 32'(e.last));
                    check("beat_sel", 32'(sel), 32'(e.port));
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic load(input int port, input int n, input int tag);
        beat_t b;
        for (int k = 1; k <= n; k++) begin
            b.last = (k == n);
            b.data = mk(tag, port, k);
            src_q[port].push_back(b);
        end
    endtask

    task automatic expect_beat(input int port, input int tag, input int b, input logic last);
        exp_t e;
        e.port = 2'(port);
        e.last = last;
        e.data = mk(tag, port, b);
        exp_q.push_back(e);
    endtask

    task automatic expect_pkt(input int port, input int tag, input int n);
        for (int k = 1; k <= n; k++) expect_beat(port, tag, k, (k == n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        pause     = 4'b0000;
        out_ready = 1'b1;
        drive();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        pause     = 4'b0000;
        acc       = 4'b0000;
        gorder[0] = 0; gorder[1] = 1; gorder[2] = 2; gorder[3] = 3; gorder[4] = 0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();

        // T1: single 3-beat packet on port 1.
        load(1, 3, 8'h11);
        expect_pkt(1, 8'h11, 3);
        drive();
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_sel", 32'(sel), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'b0010);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        tick();
        tick();
        check("t1_busy_mid", 32'(busy), 32'd1);
        tick();
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // T2: all four valid with single-beat packets; port 0 has a second packet queued.
        do_reset();
        load(0, 1, 8'h21);
        load(0, 1, 8'h22);
        load(1, 1, 8'h21);
        load(2, 1, 8'h21);
        load(3, 1, 8'h21);
        expect_pkt(0, 8'h21, 1);
        expect_pkt(1, 8'h21, 1);
        expect_pkt(2, 8'h21, 1);
        expect_pkt(3, 8'h21, 1);
        expect_pkt(0, 8'h22, 1);
        drive();
        for (int g = 0; g < 5; g++) begin
            tick();
            check("t2_sel", 32'(sel), 32'(gorder[g]));
            check("t2_busy", 32'(busy), 32'd1);
            tick();
            check("t2_gap", 32'(busy), 32'd0);
        end
        check("t2_drain", 32'(exp_q.size()), 32'd0);

        // T3: port 2 stalled 5 cycles; a 5-beat packet also proves stalls do not count toward the limit.
        load(2, 5, 8'h31);
        expect_beat(2, 8'h31, 1, 1'b0);
        expect_beat(2, 8'h31, 2, 1'b0);
        expect_beat(2, 8'h31, 3, 1'b0);
        expect_beat(2, 8'h31, 4, 1'b1);
        expect_beat(2, 8'h31, 5, 1'b1);
        drive();
        tick();
        check("t3_sel", 32'(sel), 32'd2);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_out_valid", 32'(out_valid), 32'd1);
            check("t3_out_data", out_data, mk(8'h31, 2, 2));
            check("t3_in_ready", 32'(in_ready), 32'd0);
            check("t3_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        wait_drain("t3", 20);
        check("t3_idle", 32'(busy), 32'd0);

        // T6: granted port 3 drops valid for 2 cycles while port 1 becomes valid.
        load(3, 3, 8'h61);
        expect_pkt(3, 8'h61, 3);
        drive();
        tick();
        check("t6_sel", 32'(sel), 32'd3);
        tick();
        pause = 4'b1000;
        load(1, 1, 8'h62);
        expect_pkt(1, 8'h62, 1);
        drive();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t6_sel_hold", 32'(sel), 32'd3);
            check("t6_out_valid", 32'(out_valid), 32'd0);
            check("t6_in_ready", 32'(in_ready), 32'b1000);
        end
        pause = 4'b0000;
        drive();
        wait_drain("t6", 20);

        // T5: reset during beat 2 of a port-1 packet, then all four valid.
        do_reset();
        load(1, 4, 8'h51);
        expect_pkt(1, 8'h51, 4);
        drive();
        tick();
        check("t5_sel", 32'(sel), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            load(i, 1, 8'h52);
            expect_pkt(i, 8'h52, 1);
        end
        reset = 1'b0;
        drive();
        tick();
        check("t5_regrant_sel", 32'(sel), 32'd0);
        check("t5_regrant_busy", 32'(busy), 32'd1);
        wait_drain("t5", 20);

        // T4: 10-beat packet on port 0 with port 3 waiting; beat limit is 4.
        do_reset();
        load(0, 10, 8'h41);
        load(3, 1, 8'h42);
        for (int k = 1; k <= 4; k++) expect_beat(0, 8'h41, k, (k == 4));
        expect_pkt(3, 8'h42, 1);
        for (int k = 5; k <= 8; k++) expect_beat(0, 8'h41, k, (k == 8));
        expect_beat(0, 8'h41, 9, 1'b0);
        expect_beat(0, 8'h41, 10, 1'b1);
        drive();
        tick();
        check("t4_sel0", 32'(sel), 32'd0);
        repeat (4) tick();
        check("t4_forced_release", 32'(busy), 32'd0);
        tick();
        check("t4_sel3", 32'(sel), 32'd3);
        check("t4_busy3", 32'(busy), 32'd1);
        wait_drain("t4", 40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
